// File: rtl/code_lock_ctrl.sv
// Code entry controller: sets or verifies a CODE_LEN-digit code, counts failures, locks out.
// Optional macro INPUT_TIMEOUT_EN discards a partial entry after TIMEOUT_CYCLES idle cycles.

module code_lock_ctrl #(
    parameter int unsigned CODE_LEN                        = 6,
    parameter int unsigned DIGIT_W                         = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE    = '0,
    parameter int unsigned MAX_TRIES                       = 3,
    parameter int unsigned LOCK_CYCLES                     = 1000,
    parameter int unsigned TIMEOUT_CYCLES                  = 5000
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_code_set,
    input  logic                              i_key_sured,
    input  logic [DIGIT_W-1:0]                i_key_value,
    output logic                              o_code_finish,
    output logic                              o_success,
    output logic                              o_fail,
    output logic                              o_led_set,
    output logic                              o_locked,
    output logic [$clog2(CODE_LEN+1)-1:0]     o_digit_cnt,
    output logic [3:0]                        o_fail_cnt
);

    localparam int unsigned CntW  = $clog2(CODE_LEN + 1);
    localparam int unsigned LkW   = $clog2(LOCK_CYCLES + 1);
    localparam int unsigned CodeW = CODE_LEN * DIGIT_W;

    typedef enum logic [1:0] {StIdle, StSet, StVerify, StLock} state_e;

    state_e              r_state, w_state_next;
    logic                r_key_prev, r_set_prev;
    logic [DIGIT_W-1:0]  r_buf [CODE_LEN-1];
    logic [DIGIT_W-1:0]  w_buf_next [CODE_LEN-1];
    logic [CodeW-1:0]    r_code, w_code_next;
    logic [CntW-1:0]     r_digit_cnt, w_digit_cnt_next;
    logic [3:0]          r_fail_cnt, w_fail_cnt_next;
    logic                r_success, w_success_next;
    logic                r_fail, w_fail_next;
    logic                r_finish, w_finish_next;
    logic [LkW-1:0]      r_lock_cnt, w_lock_cnt_next;

    logic                w_key_ev, w_set_ev, w_last, w_match, w_timeout;
    logic [CodeW-1:0]    w_entry;
    logic [4:0]          w_fail_inc;

    assign w_key_ev   = i_key_sured & ~r_key_prev;
    assign w_set_ev   = i_code_set & ~r_set_prev;
    assign w_last     = (r_digit_cnt == CntW'(CODE_LEN - 1));
    assign w_fail_inc = {1'b0, r_fail_cnt} + 5'd1;

    // Full entry assembled with the digit arriving this cycle as the final (LS) digit.
    always_comb begin
        w_entry = '0;
        for (int i = 0; i < CODE_LEN - 1; i++) begin
            w_entry[(CODE_LEN-i)*DIGIT_W-1 -: DIGIT_W] = r_buf[i];
        end
        w_entry[DIGIT_W-1:0] = i_key_value;
    end

    assign w_match = (w_entry == r_code);

`ifdef INPUT_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);

    logic [ToW-1:0] r_to_cnt, w_to_cnt_next;
    logic           w_entry_active;

    assign w_entry_active = ((r_state == StSet) || (r_state == StVerify)) && (r_digit_cnt != '0);
    assign w_timeout      = w_entry_active && (r_to_cnt == ToW'(TIMEOUT_CYCLES - 1));

    // Reloads on every accepted digit; only runs while a partial entry exists.
    always_comb begin
        w_to_cnt_next = '0;
        if (w_entry_active && !w_key_ev && !w_set_ev && !w_timeout) begin
            w_to_cnt_next = r_to_cnt + ToW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= w_to_cnt_next;
        end
    end
`else
    logic [31:0] w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        w_state_next     = r_state;
        w_digit_cnt_next = r_digit_cnt;
        w_fail_cnt_next  = r_fail_cnt;
        w_success_next   = r_success;
        w_fail_next      = r_fail;
        w_finish_next    = 1'b0;
        w_code_next      = r_code;
        w_lock_cnt_next  = r_lock_cnt;
        w_buf_next       = r_buf;

        case (r_state)
            StIdle: begin
                if (w_set_ev) begin
                    w_state_next     = StSet;
                    w_digit_cnt_next = '0;
                    w_success_next   = 1'b0;
                    w_fail_next      = 1'b0;
                end else if (w_key_ev) begin
                    w_state_next     = StVerify;
                    w_buf_next[0]    = i_key_value;
                    w_digit_cnt_next = CntW'(1);
                    w_success_next   = 1'b0;
                    w_fail_next      = 1'b0;
                end
            end

            StSet, StVerify: begin
                // code_set has priority; a key edge in the same cycle is dropped.
                if (w_set_ev) begin
                    w_state_next     = StSet;
                    w_digit_cnt_next = '0;
                    w_success_next   = 1'b0;
                    w_fail_next      = 1'b0;
                end else if (w_key_ev) begin
                    if (w_last) begin
                        w_finish_next    = 1'b1;
                        w_digit_cnt_next = '0;
                        w_state_next     = StIdle;
                        if (r_state == StSet) begin
                            w_code_next = w_entry;
                        end else if (w_match) begin
                            w_success_next  = 1'b1;
                            w_fail_cnt_next = '0;
                        end else begin
                            w_fail_next = 1'b1;
                            if (w_fail_inc >= 5'(MAX_TRIES)) begin
                                w_fail_cnt_next = 4'(MAX_TRIES);
                                w_state_next    = StLock;
                                w_lock_cnt_next = '0;
                            end else begin
                                w_fail_cnt_next = w_fail_inc[3:0];
                            end
                        end
                    end else begin
                        for (int i = 0; i < CODE_LEN - 1; i++) begin
                            if (r_digit_cnt == CntW'(i)) begin
                                w_buf_next[i] = i_key_value;
                            end
                        end
                        w_digit_cnt_next = r_digit_cnt + CntW'(1);
                    end
                end else if (w_timeout) begin
                    w_state_next     = StIdle;
                    w_digit_cnt_next = '0;
                end
            end

            StLock: begin
                if (r_lock_cnt == LkW'(LOCK_CYCLES - 1)) begin
                    w_state_next    = StIdle;
                    w_fail_cnt_next = '0;
                    w_fail_next     = 1'b0;
                    w_lock_cnt_next = '0;
                end else begin
                    w_lock_cnt_next = r_lock_cnt + LkW'(1);
                end
            end

            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Edge registers track inputs in every state so nothing stale fires when lockout ends.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_key_prev  <= 1'b0;
            r_set_prev  <= 1'b0;
            r_code      <= DEFAULT_CODE;
            r_digit_cnt <= '0;
            r_fail_cnt  <= '0;
            r_success   <= 1'b0;
            r_fail      <= 1'b0;
            r_finish    <= 1'b0;
            r_lock_cnt  <= '0;
            for (int i = 0; i < CODE_LEN - 1; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_state     <= w_state_next;
            r_key_prev  <= i_key_sured;
            r_set_prev  <= i_code_set;
            r_code      <= w_code_next;
            r_digit_cnt <= w_digit_cnt_next;
            r_fail_cnt  <= w_fail_cnt_next;
            r_success   <= w_success_next;
            r_fail      <= w_fail_next;
            r_finish    <= w_finish_next;
            r_lock_cnt  <= w_lock_cnt_next;
            for (int i = 0; i < CODE_LEN - 1; i++) begin
                r_buf[i] <= w_buf_next[i];
            end
        end
    end

    assign o_code_finish = r_finish;
    assign o_success     = r_success;
    assign o_fail        = r_fail;
    assign o_led_set     = (r_state == StSet);
    assign o_locked      = (r_state == StLock);
    assign o_digit_cnt   = r_digit_cnt;
    assign o_fail_cnt    = r_fail_cnt;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Scoreboard bench for code_lock_ctrl: expected code_finish results are queued by the
// stimulus and popped by a monitor whenever the DUT pulses code_finish.

module tb_code_lock_ctrl;

    typedef struct packed {
        logic       succ;
        logic       fail;
        logic [3:0] fc;
        logic       lk;
        logic       led;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       code_set;
    logic       key_sured;
    logic [3:0] key_value;
    logic       code_finish, success, fail, led_set, locked;
    logic [2:0] digit_cnt;
    logic [3:0] fail_cnt;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    exp_t mon_act, mon_exp;

    always #5 clk = ~clk;

    code_lock_ctrl #(
        .CODE_LEN       (6),
        .DIGIT_W        (4),
        .DEFAULT_CODE   (24'h000000),
        .MAX_TRIES      (3),
        .LOCK_CYCLES    (20),
        .TIMEOUT_CYCLES (50)
    ) u_dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_code_set    (code_set),
        .i_key_sured   (key_sured),
        .i_key_value   (key_value),
        .o_code_finish (code_finish),
        .o_success     (success),
        .o_fail        (fail),
        .o_led_set     (led_set),
        .o_locked      (locked),
        .o_digit_cnt   (digit_cnt),
        .o_fail_cnt    (fail_cnt)
    );

    function automatic exp_t mk(input logic s, input logic f, input logic [3:0] fc,
                                input logic lk, input logic led);
        mk = '{succ: s, fail: f, fc: fc, lk: lk, led: led};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: every code_finish pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && code_finish) begin
            total++;
            mon_act = mk(success, fail, fail_cnt, locked, led_set);
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL finish_extra: got %0h want none", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    bad++;
                    $display("FAIL finish_result: got %0h want %0h", mon_act, mon_exp);
                end
            end
        end
    end

    task automatic press(input logic [3:0] d, input int hold);
        @(posedge clk);
        #1 key_value = d;
        key_sured = 1'b1;
        repeat (hold) @(posedge clk);
        #1 key_sured = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic enter(input logic [23:0] code, input exp_t e, input logic exp_led);
        exp_q.push_back(e);
        for (int i = 0; i < 6; i++) begin
            press(code[23-4*i -: 4], 25);
            if (i == 4) begin
                @(negedge clk);
                check("mid_digit_cnt", digit_cnt, 5);
                check("mid_led_set", led_set, exp_led);
            end
        end
    endtask

    task automatic pulse_set();
        @(posedge clk);
        #1 code_set = 1'b1;
        repeat (3) @(posedge clk);
        #1 code_set = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic dc_bad;

        rst = 1'b1;
        code_set = 1'b0;
        key_sured = 1'b0;
        key_value = 4'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_finish", code_finish, 0);
        check("rst_success", success, 0);
        check("rst_fail", fail, 0);
        check("rst_led", led_set, 0);
        check("rst_locked", locked, 0);
        check("rst_digit_cnt", digit_cnt, 0);
        check("rst_fail_cnt", fail_cnt, 0);

        // Default code verifies.
        enter(24'h000000, mk(1, 0, 0, 0, 0), 1'b0);
        @(negedge clk);
        check("success_hold", success, 1);

        // Set a new code, then verify it right and wrong.
        pulse_set();
        @(negedge clk);
        check("set_led", led_set, 1);
        check("set_clears_success", success, 0);
        enter(24'h012345, mk(0, 0, 0, 0, 0), 1'b1);
        enter(24'h012345, mk(1, 0, 0, 0, 0), 1'b0);
        enter(24'h135790, mk(0, 1, 1, 0, 0), 1'b0);
        enter(24'h012345, mk(1, 0, 0, 0, 0), 1'b0);

        // Three consecutive failures lock the block.
        enter(24'h111111, mk(0, 1, 1, 0, 0), 1'b0);
        enter(24'h222222, mk(0, 1, 2, 0, 0), 1'b0);
        exp_q.push_back(mk(0, 1, 3, 1, 0));
        for (int i = 0; i < 5; i++) press(4'h3, 25);
        @(posedge clk);
        #1 key_value = 4'h3;
        key_sured = 1'b1;
        @(posedge clk);
        n = 0;
        dc_bad = 1'b0;
        fork
            begin
                #1 key_sured = 1'b0;
                repeat (3) @(posedge clk);
                #1 key_sured = 1'b1;
                key_value = 4'h5;
                repeat (3) @(posedge clk);
                #1 key_sured = 1'b0;
                code_set = 1'b1;
                repeat (3) @(posedge clk);
                #1 code_set = 1'b0;
                repeat (5) @(posedge clk);
                // Held across lockout exit: must not produce an event afterwards.
                #1 key_sured = 1'b1;
                repeat (15) @(posedge clk);
                #1 key_sured = 1'b0;
            end
            begin
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk);
                    if (!locked) break;
                    n++;
                    if (digit_cnt != 3'd0 || led_set) dc_bad = 1'b1;
                end
            end
        join
        check("lock_len", n, 20);
        check("lock_ignores_keys", dc_bad, 0);
        @(negedge clk);
        check("unlock_locked", locked, 0);
        check("unlock_fail_cnt", fail_cnt, 0);
        check("unlock_fail", fail, 0);
        check("unlock_no_stale", digit_cnt, 0);

        enter(24'h444444, mk(0, 1, 1, 0, 0), 1'b0);

        // A long-held key gives exactly one digit.
        press(4'h7, 200);
        @(negedge clk);
        check("held_one_digit", digit_cnt, 1);
        press(4'h1, 25);
        press(4'h2, 25);
        @(negedge clk);
        check("three_digits", digit_cnt, 3);

        // code_set and key rise together: set wins, digit dropped, fail_cnt kept.
        @(posedge clk);
        #1 code_set = 1'b1;
        key_sured = 1'b1;
        key_value = 4'h4;
        @(posedge clk);
        @(negedge clk);
        check("abort_led", led_set, 1);
        check("abort_digit_cnt", digit_cnt, 0);
        check("abort_fail_cnt", fail_cnt, 1);
        repeat (24) @(posedge clk);
        #1 code_set = 1'b0;
        key_sured = 1'b0;
        repeat (2) @(posedge clk);

        // Digits above 9 are legal.
        enter(24'hFA9876, mk(0, 0, 1, 0, 0), 1'b1);
        enter(24'hFA9876, mk(1, 0, 0, 0, 0), 1'b0);

        // Partial entry left idle.
        press(4'h3, 25);
        press(4'h4, 25);
        @(negedge clk);
        check("partial_cnt", digit_cnt, 2);
        repeat (60) @(posedge clk);
        @(negedge clk);
`ifdef INPUT_TIMEOUT_EN
        check("timeout_digit_cnt", digit_cnt, 0);
`else
        check("no_timeout_digit_cnt", digit_cnt, 2);
`endif
        check("timeout_fail", fail, 0);
        check("timeout_fail_cnt", fail_cnt, 0);
        check("timeout_locked", locked, 0);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
